// File: rtl/ctrl_seq.sv
// Main controller sequencer: a registered FSM that steps through fetch, accumulator init,
// N-tap MAC loop, writeback and optional output emit, one instruction at a time.
module ctrl_seq #(
  parameter int TAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             out_ready,
  input  logic [TAP_W-1:0] instr_taps,
  input  logic             instr_emit,
  input  logic             instr_last,
  output logic [2:0]       fsm_state,
  output logic [TAP_W-1:0] loop_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_PCINC  = 3'd0,
    S_FETCH  = 3'd1,
    S_AINIT  = 3'd2,
    S_MAC    = 3'd3,
    S_WB0    = 3'd4,
    S_WB1    = 3'd5,
    S_EMIT   = 3'd6,
    S_WAITIN = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] cnt_q, cnt_d;
  logic             emit_q, emit_d;
  logic             last_q, last_d;
  logic             busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAITIN;
      cnt_q   <= '0;
      emit_q  <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      emit_q  <= emit_d;
      last_q  <= last_d;
      busy_q  <= (state_d != S_WAITIN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit_d  = emit_q;
    last_d  = last_q;
    unique case (state_q)
      S_WAITIN: if (in_valid) state_d = S_FETCH;
      S_FETCH:  state_d = S_AINIT;
      S_AINIT: begin
        emit_d  = instr_emit;
        last_d  = instr_last;
        cnt_d   = instr_taps;
        state_d = (instr_taps == '0) ? S_WB0 : S_MAC;
      end
      S_MAC: begin
        // The counter reaches 0 exactly as the loop exits, so it never wraps.
        if (cnt_q != '0) cnt_d = cnt_q - TAP_W'(1);
        if (cnt_q <= TAP_W'(1)) state_d = S_WB0;
      end
      S_WB0: state_d = S_WB1;
      S_WB1: begin
        if (emit_q)      state_d = S_EMIT;
        else if (last_q) state_d = S_WAITIN;
        else             state_d = S_PCINC;
      end
      S_EMIT: begin
        if (out_ready) state_d = last_q ? S_WAITIN : S_PCINC;
      end
      S_PCINC: state_d = S_FETCH;
      default: state_d = S_WAITIN;
    endcase
  end

  assign fsm_state = state_q;
  assign loop_cnt  = cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: programs are expanded into a per-cycle table of
// stimulus and expected outputs, then replayed against the DUT cycle by cycle.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] instr_taps;
  logic       instr_emit;
  logic       instr_last;
  logic [2:0] fsm_state;
  logic [7:0] loop_cnt;
  logic       busy;

  ctrl_seq #(.TAP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .instr_taps (instr_taps),
    .instr_emit (instr_emit),
    .instr_last (instr_last),
    .fsm_state  (fsm_state),
    .loop_cnt   (loop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // One table entry per clock cycle: inputs driven in that cycle, outputs expected in it.
  typedef struct {
    logic       rst;
    logic       iv;
    logic       ordy;
    logic [7:0] taps;
    logic       emit;
    logic       last;
    logic [2:0] st;
    logic [7:0] cnt;
  } ent_t;

  ent_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [2:0] st, input logic [7:0] cnt,
                      input logic iv, input logic ordy, input logic r);
    ent_t e;
    e.rst  = r;
    e.iv   = iv;
    e.ordy = ordy;
    e.taps = 8'($urandom_range(0, 255));
    e.emit = rbit();
    e.last = rbit();
    e.st   = st;
    e.cnt  = cnt;
    tbl.push_back(e);
  endtask

  // Idle in WAIT_IN for n cycles, then present a sample that gets accepted.
  task automatic addIdle(input int n);
    for (int i = 0; i < n; i++) push(3'd7, 8'd0, 1'b0, rbit(), 1'b0);
    push(3'd7, 8'd0, 1'b1, rbit(), 1'b0);
  endtask

  // One instruction from fetch to the point where the next one (or WAIT_IN) begins.
  task automatic addInstr(input int taps, input logic emit, input logic last, input int stall);
    push(3'd1, 8'd0, rbit(), rbit(), 1'b0);
    push(3'd2, 8'd0, rbit(), rbit(), 1'b0);
    tbl[tbl.size()-1].taps = 8'(taps);
    tbl[tbl.size()-1].emit = emit;
    tbl[tbl.size()-1].last = last;
    for (int c = taps; c >= 1; c--) push(3'd3, 8'(c), rbit(), rbit(), 1'b0);
    push(3'd4, 8'd0, rbit(), rbit(), 1'b0);
    push(3'd5, 8'd0, rbit(), rbit(), 1'b0);
    if (emit) begin
      for (int i = 0; i < stall; i++) push(3'd6, 8'd0, rbit(), 1'b0, 1'b0);
      push(3'd6, 8'd0, rbit(), 1'b1, 1'b0);
    end
    if (!last) push(3'd0, 8'd0, rbit(), rbit(), 1'b0);
  endtask

  task automatic pinTrace(input string name, input int start, input int exp[], input int len);
    for (int i = 0; i < len; i++) begin
      vectors++;
      if (int'(tbl[start+i].st) != exp[i]) begin
        miscompares++;
        $display("[TB] FAIL model_%s[%0d] got=%0d exp=%0d", name, i, tbl[start+i].st, exp[i]);
      end
    end
  endtask

  task automatic applyStimulus(input int k);
    rst        = tbl[k].rst;
    in_valid   = tbl[k].iv;
    out_ready  = tbl[k].ordy;
    instr_taps = tbl[k].taps;
    instr_emit = tbl[k].emit;
    instr_last = tbl[k].last;
  endtask

  task automatic checkOutput(input int k);
    logic expBusy;
    expBusy = (tbl[k].st != 3'd7);
    vectors++;
    if (fsm_state !== tbl[k].st) begin
      miscompares++;
      $display("[TB] FAIL fsm_state cyc=%0d got=%0d exp=%0d", k, fsm_state, tbl[k].st);
    end
    vectors++;
    if (loop_cnt !== tbl[k].cnt) begin
      miscompares++;
      $display("[TB] FAIL loop_cnt cyc=%0d got=%0d exp=%0d", k, loop_cnt, tbl[k].cnt);
    end
    vectors++;
    if (busy !== expBusy) begin
      miscompares++;
      $display("[TB] FAIL busy cyc=%0d got=%0d exp=%0d", k, busy, expBusy);
    end
  endtask

  initial begin
    int s2, s3, s4;
    int exp2[] = '{7, 1, 2, 3, 3, 3, 4, 5, 6, 7};
    int exp3[] = '{7, 1, 2, 4, 5, 7};
    int exp4[] = '{7, 1, 2, 3, 3, 4, 5, 0, 1, 2, 3, 4, 5, 6, 7};
    int nInstr;

    // Reset in the middle of a MAC loop, held for two cycles.
    addIdle(1);
    push(3'd1, 8'd0, 1'b0, 1'b0, 1'b0);
    push(3'd2, 8'd0, 1'b0, 1'b0, 1'b0);
    tbl[tbl.size()-1].taps = 8'd10;
    for (int c = 10; c >= 5; c--) push(3'd3, 8'(c), 1'b0, 1'b0, (c == 5));
    push(3'd7, 8'd0, 1'b1, 1'b1, 1'b1);

    s2 = tbl.size();
    addIdle(0);
    addInstr(3, 1'b1, 1'b1, 0);
    s3 = tbl.size();
    addIdle(0);
    addInstr(0, 1'b0, 1'b1, 0);
    s4 = tbl.size();
    addIdle(0);
    addInstr(2, 1'b0, 1'b0, 0);
    addInstr(1, 1'b1, 1'b1, 0);
    addIdle(0);
    addInstr(1, 1'b1, 1'b1, 4);
    addIdle(2);
    addInstr(255, 1'b0, 1'b1, 0);

    for (int p = 0; p < 40; p++) begin
      addIdle($urandom_range(0, 3));
      nInstr = $urandom_range(1, 3);
      for (int i = 0; i < nInstr; i++)
        addInstr(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6), rbit(),
                 (i == nInstr - 1), $urandom_range(0, 3));
    end
    addIdle(3);

    pinTrace("single", s2, exp2, 10);
    pinTrace("zero", s3, exp3, 6);
    pinTrace("two", s4, exp4, 15);

    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    instr_taps = 8'd0;
    instr_emit = 1'b0;
    instr_last = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      checkOutput(k);
      applyStimulus(k);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
